start_stop_cond: RTL and testbench

//   Upstream input conditioner for the start/stop-controlled mod-14 counter stage.
//   - Synchronises two raw, asynchronous push-button inputs and debounces each one.
//   - Emits clean single-cycle start/stop pulses that drive that stage directly.
//   - Tracks a run flag mirroring the downstream count-enable state.
//   - Resolves start/stop collisions locally, so the downstream stage never sees both pulses together.

---
 rtl/start_stop_cond.sv | 163 ++++++++++++++++
 tb/tb_start_stop_cond.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/start_stop_cond.sv
// -----------------------------------------------------------------------------
// start_stop_cond
//   Input conditioner for a start/stop-controlled counter stage. Each raw push
//   button is synchronised (2 flops) and debounced by a small FSM. A clean
//   press event becomes a single-cycle start or stop pulse, with stop taking
//   priority when both arrive together. A run flag tracks the pulses.
//
//   Build option:
//     START_TOGGLE_EN  - start_btn acts as a run/stop toggle; stop_btn unchanged.
//
//   Parameters:
//     DB_CYCLES  stable synchronised samples needed to accept a change (>=1)
//     DB_W       debounce counter width, 2**DB_W > DB_CYCLES-1
//
//   Ports:
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     start_btn  raw asynchronous start button (active high)
//     stop_btn   raw asynchronous stop button (active high)
//     start      one-cycle start pulse (registered)
//     stop       one-cycle stop pulse (registered)
//     running    run flag (registered)
// -----------------------------------------------------------------------------
module start_stop_cond #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_btn,
    input  logic stop_btn,
    output logic start,
    output logic stop,
    output logic running
);

    localparam int unsigned NB = 2;  // index 0 = start button, 1 = stop button
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } db_state_e;

    logic [NB-1:0]   btn_raw;
    logic [NB-1:0]   meta_q;
    logic [NB-1:0]   sync_q;
    db_state_e       state_q [NB];
    db_state_e       state_d [NB];
    logic [DB_W-1:0] cnt_q   [NB];
    logic [DB_W-1:0] cnt_d   [NB];
    logic [NB-1:0]   evt_c;

    logic start_evt_c;
    logic stop_evt_c;
    logic start_q, start_d;
    logic stop_q,  stop_d;
    logic running_q, running_d;

    assign btn_raw = {stop_btn, start_btn};

    // Debounce FSM next state; evt_c marks the transition into PRESSED so the
    // registered pulse appears in the same cycle the FSM first sits in PRESSED.
    always_comb begin : db_fsm_next
        for (int i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            evt_c[i]   = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (sync_q[i]) begin
                        state_d[i] = PRESS_DB;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_DB: begin
                    if (!sync_q[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        evt_c[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync_q[i]) begin
                        state_d[i] = REL_DB;
                        cnt_d[i]   = '0;
                    end
                end
                REL_DB: begin
                    if (sync_q[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Event-to-pulse mapping and run flag; stop always wins a collision.
    always_comb begin : out_map
        start_evt_c = evt_c[0];
        stop_evt_c  = evt_c[1];

        running_d = running_q;
        if (stop_q) begin
            running_d = 1'b0;
        end else if (start_q) begin
            running_d = 1'b1;
        end

`ifdef START_TOGGLE_EN
        // Toggle decision uses the run state as it will be after any pulse
        // already in flight, so a toggle right after a pulse is not misread.
        start_d = start_evt_c & ~stop_evt_c & ~running_d;
        stop_d  = stop_evt_c | (start_evt_c & running_d);
`else
        start_d = start_evt_c & ~stop_evt_c;
        stop_d  = stop_evt_c;
`endif
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            meta_q    <= '0;
            sync_q    <= '0;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            meta_q    <= btn_raw;
            sync_q    <= meta_q;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            start_q   <= start_d;
            stop_q    <= stop_d;
            running_q <= running_d;
        end
    end

    assign start   = start_q;
    assign stop    = stop_q;
    assign running = running_q;

endmodule

// File: tb/tb_start_stop_cond.sv
// -----------------------------------------------------------------------------
// tb_start_stop_cond
//   Directed bench for start_stop_cond. Inputs change 1 time unit after a
//   rising edge, so the next rising edge is "edge 1" of a stimulus step;
//   outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_start_stop_cond;

`ifdef START_TOGGLE_EN
    localparam int unsigned TB_DB = 1;
`else
    localparam int unsigned TB_DB = 4;
`endif
    localparam int unsigned TB_W = 3;
    localparam int          LAT  = int'(TB_DB) + 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic start_btn = 1'b0;
    logic stop_btn  = 1'b0;
    logic start;
    logic stop;
    logic running;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    start_stop_cond #(
        .DB_CYCLES (TB_DB),
        .DB_W      (TB_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .start     (start),
        .stop      (stop),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic s, input logic p, input logic r);
        check({tag, "_start"},   start,   s);
        check({tag, "_stop"},    stop,    p);
        check({tag, "_running"}, running, r);
    endtask

    // Run n edges. start expected high only at edge s_at, stop only at p_at
    // (0 = never); running is run0 before edge r_at and run1 from it on.
    task automatic watch(input string tag, input int n, input int s_at, input int p_at,
                         input int r_at, input logic run0, input logic run1);
        for (int i = 1; i <= n; i++) begin
            tick();
            check_outs($sformatf("%s@%0d", tag, i), 1'(i == s_at), 1'(i == p_at),
                       (r_at != 0 && i >= r_at) ? run1 : run0);
        end
    endtask

    initial begin
        // Reset state, including async assertion at time 0.
        #1;
        check_outs("rst_t0", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_outs("rst_hold", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        watch("idle", 3, 0, 0, 0, 1'b0, 1'b0);

`ifndef START_TOGGLE_EN
        // Clean press: pulse at edge 7, running from edge 8, no repeats.
        start_btn = 1'b1;
        watch("t1_press", 12, LAT, 0, LAT + 1, 1'b0, 1'b1);
        start_btn = 1'b0;
        watch("t1_rel", 10, 0, 0, 0, 1'b1, 1'b1);

        // Press bounce: H H L H H H L, then stable high.
        begin
            logic [6:0] pat;
            pat = 7'b1101110;
            for (int k = 6; k >= 0; k--) begin
                start_btn = pat[k];
                tick();
                check_outs($sformatf("t2_bounce@%0d", 7 - k), 1'b0, 1'b0, 1'b1);
            end
        end
        start_btn = 1'b1;
        watch("t2_final", 10, LAT, 0, 0, 1'b1, 1'b1);
        start_btn = 1'b0;
        watch("t2_rel", 10, 0, 0, 0, 1'b1, 1'b1);

        // Reset mid-debounce with start_btn held.
        start_btn = 1'b1;
        watch("t5_pre", 4, 0, 0, 0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_outs("t5_rst_now", 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_outs($sformatf("t5_rst@%0d", k), 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        watch("t5_post", 10, LAT, 0, LAT + 1, 1'b0, 1'b1);
        start_btn = 1'b0;
        watch("t5_rel", 10, 0, 0, 0, 1'b1, 1'b1);

        // Stop press clears running, then release bounce L L H H L.
        stop_btn = 1'b1;
        watch("t4_press", 10, 0, LAT, LAT + 1, 1'b1, 1'b0);
        begin
            logic [3:0] pat;
            pat = 4'b0011;
            for (int k = 3; k >= 0; k--) begin
                stop_btn = pat[k];
                tick();
                check_outs($sformatf("t4_bounce@%0d", 4 - k), 1'b0, 1'b0, 1'b0);
            end
        end
        stop_btn = 1'b0;
        watch("t4_fall", 8, 0, 0, 0, 1'b0, 1'b0);
        // A fresh press pulses on time only if the FSM really returned to IDLE.
        stop_btn = 1'b1;
        watch("t4_again", 10, 0, LAT, 0, 1'b0, 1'b0);
        stop_btn = 1'b0;
        watch("t4_rel", 10, 0, 0, 0, 1'b0, 1'b0);

        // Collision: stop wins, start dropped, running stays 0.
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        watch("t3_coll", 12, 0, LAT, 0, 1'b0, 1'b0);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        watch("t3_rel", 10, 0, 0, 0, 1'b0, 1'b0);
`else
        // Toggle mode: first press starts, second press stops, each at edge 4.
        start_btn = 1'b1;
        watch("t6_p1", 6, LAT, 0, LAT + 1, 1'b0, 1'b1);
        start_btn = 1'b0;
        watch("t6_r1", 6, 0, 0, 0, 1'b1, 1'b1);
        start_btn = 1'b1;
        watch("t6_p2", 6, 0, LAT, LAT + 1, 1'b1, 1'b0);
        start_btn = 1'b0;
        watch("t6_r2", 6, 0, 0, 0, 1'b0, 1'b0);

        // stop_btn still stops; while idle it leaves running at 0.
        stop_btn = 1'b1;
        watch("t6_stop", 6, 0, LAT, 0, 1'b0, 1'b0);
        stop_btn = 1'b0;
        watch("t6_stop_rel", 6, 0, 0, 0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
